// File: rtl/ofs_fim_pcie_pkg.sv
// Shared PCIe RX definitions: routing enum, fmt_type codes and header route decode.
package ofs_fim_pcie_pkg;

  // Power-user header occupies the low 256 bits of the SOP beat.
  localparam int unsigned HDR_W = 256;

  // fmt_type codes (fmt[2:0] in bits 7:5, type in bits 4:0).
  localparam logic [7:0] FMT_MRD32 = 8'h00;
  localparam logic [7:0] FMT_MRD64 = 8'h20;
  localparam logic [7:0] FMT_MWR32 = 8'h40;
  localparam logic [7:0] FMT_MWR64 = 8'h60;
  localparam logic [7:0] FMT_CPL   = 8'h0A;
  localparam logic [7:0] FMT_CPLD  = 8'h4A;

  typedef enum logic {RX_ROUTE_MMIO, RX_ROUTE_AFU} t_rx_route;

  typedef enum logic {StIdle, StInPkt} t_rx_state;

  // Header fields used for routing:
  //   [31:24]   fmt_type
  //   [95:64]   address[63:32] (4DW requests only)
  //   [127:96]  address[31:0]
  //   [162:160] pf_num
  //   [173:163] vf_num
  //   [174]     vf_active
  //   [181:178] bar_number
  function automatic t_rx_route decode_rx_route(input logic [HDR_W-1:0] hdr,
                                                input logic [2:0]       pf,
                                                input logic [3:0]       bar,
                                                input logic [63:0]      limit);
    logic [7:0]  fmt_type;
    logic [63:0] addr;
    logic        is_mem;
    logic        hit;
    fmt_type = hdr[31:24];
    case (fmt_type)
      FMT_MRD32, FMT_MRD64, FMT_MWR32, FMT_MWR64: is_mem = 1'b1;
      default:                                    is_mem = 1'b0;
    endcase
    // fmt[0] (bit 5) selects the 4DW header carrying a 64-bit address.
    if (fmt_type[5]) begin
      addr = {hdr[95:64], hdr[127:96]};
    end else begin
      addr = {32'h0, hdr[127:96]};
    end
    hit = is_mem && (hdr[162:160] == pf) && !hdr[174] && (hdr[181:178] == bar) &&
          (addr < limit);
    return hit ? RX_ROUTE_MMIO : RX_ROUTE_AFU;
  endfunction

endpackage

// File: rtl/pcie_ss_axis_if.sv
// AXI-S stream bundle used between the PCIe SS and its RX/TX clients.
interface pcie_ss_axis_if #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned USER_W = 10
);
  logic                tvalid;
  logic                tready;
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic [USER_W-1:0]   tuser_vendor;

  modport source (output tvalid, tdata, tkeep, tlast, tuser_vendor, input tready);
  modport sink   (input tvalid, tdata, tkeep, tlast, tuser_vendor, output tready);
endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-S register slice. Upstream tready comes straight from a flop, so the
// downstream tready never reaches the upstream side combinationally.
module axis_skid_buf #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned USER_W = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  pcie_ss_axis_if.sink   in_st,
  pcie_ss_axis_if.source out_st
);
  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned BEAT_W = DATA_W + KEEP_W + 1 + USER_W;

  logic [BEAT_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_d;
  logic              rdy_q;
  logic              push;
  logic              pop;

  assign in_st.tready  = rdy_q;
  assign push          = in_st.tvalid && rdy_q;
  assign out_st.tvalid = (cnt_q != 2'd0);
  assign pop           = (cnt_q != 2'd0) && out_st.tready;
  assign {out_st.tdata, out_st.tkeep, out_st.tlast, out_st.tuser_vendor} = mem_q[rd_ptr_q];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; ready is held low through reset and tracks occupancy < 2 after.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d < 2'd2);
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Beat storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_st.tdata, in_st.tkeep, in_st.tlast, in_st.tuser_vendor};
    end
  end

endmodule

// File: rtl/pcie_rx_demux.sv
// Steers each RX TLP, whole and in order, to the FIM MMIO sink or the AFU sink.
// The route is decoded on the SOP beat and held for the rest of the packet.
module pcie_rx_demux
  import ofs_fim_pcie_pkg::*;
#(
  parameter int unsigned FIM_PF_NUM     = 0,
  parameter int unsigned FIM_BAR_NUM    = 0,
  parameter logic [63:0] FIM_ADDR_LIMIT = 64'h0008_0000,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DATA_W         = 512,
  parameter int unsigned USER_W         = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  pcie_ss_axis_if.sink     i_pcie_rx_st,
  pcie_ss_axis_if.source   o_mmio_rx_st,
  pcie_ss_axis_if.source   o_afu_rx_st,
  output logic [CNT_W-1:0] o_mmio_tlp_cnt,
  output logic [CNT_W-1:0] o_afu_tlp_cnt,
  output logic             o_in_pkt
);
  localparam logic [2:0] PF_SEL  = FIM_PF_NUM[2:0];
  localparam logic [3:0] BAR_SEL = FIM_BAR_NUM[3:0];

  pcie_ss_axis_if #(.DATA_W(DATA_W), .USER_W(USER_W)) mmio_in ();
  pcie_ss_axis_if #(.DATA_W(DATA_W), .USER_W(USER_W)) afu_in ();

  t_rx_state  state_q;
  t_rx_state  state_d;
  t_rx_route  route_q;
  t_rx_route  route_d;
  t_rx_route  route_dec;
  t_rx_route  route_cur;
  logic       accept;
  logic       sop_accept;
  logic [CNT_W-1:0] mmio_cnt_q;
  logic [CNT_W-1:0] afu_cnt_q;

  assign route_dec = decode_rx_route(i_pcie_rx_st.tdata[HDR_W-1:0], PF_SEL, BAR_SEL,
                                     FIM_ADDR_LIMIT);
  // Mid-packet beats carry payload, so only the SOP beat is decoded.
  assign route_cur = (state_q == StIdle) ? route_dec : route_q;

  assign i_pcie_rx_st.tready = (route_cur == RX_ROUTE_MMIO) ? mmio_in.tready : afu_in.tready;
  assign accept              = i_pcie_rx_st.tvalid && i_pcie_rx_st.tready;
  assign sop_accept          = accept && (state_q == StIdle);

  // Payload fans out to both slices; only tvalid selects the destination.
  assign mmio_in.tvalid       = i_pcie_rx_st.tvalid && (route_cur == RX_ROUTE_MMIO);
  assign mmio_in.tdata        = i_pcie_rx_st.tdata;
  assign mmio_in.tkeep        = i_pcie_rx_st.tkeep;
  assign mmio_in.tlast        = i_pcie_rx_st.tlast;
  assign mmio_in.tuser_vendor = i_pcie_rx_st.tuser_vendor;

  assign afu_in.tvalid        = i_pcie_rx_st.tvalid && (route_cur == RX_ROUTE_AFU);
  assign afu_in.tdata         = i_pcie_rx_st.tdata;
  assign afu_in.tkeep         = i_pcie_rx_st.tkeep;
  assign afu_in.tlast         = i_pcie_rx_st.tlast;
  assign afu_in.tuser_vendor  = i_pcie_rx_st.tuser_vendor;

  assign o_in_pkt       = (state_q == StInPkt);
  assign o_mmio_tlp_cnt = mmio_cnt_q;
  assign o_afu_tlp_cnt  = afu_cnt_q;

  // Packet framing: enter InPkt on a non-last SOP, leave on the accepted tlast beat.
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    unique case (state_q)
      StIdle: begin
        if (accept && !i_pcie_rx_st.tlast) begin
          state_d = StInPkt;
          route_d = route_dec;
        end
      end
      StInPkt: begin
        if (accept && i_pcie_rx_st.tlast) state_d = StIdle;
      end
    endcase
  end

  // FSM state and latched route.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      route_q <= RX_ROUTE_MMIO;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  // Per-destination TLP counters, bumped once per accepted SOP; wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mmio_cnt_q <= '0;
      afu_cnt_q  <= '0;
    end else if (sop_accept) begin
      if (route_dec == RX_ROUTE_MMIO) mmio_cnt_q <= mmio_cnt_q + 1'b1;
      else                            afu_cnt_q  <= afu_cnt_q + 1'b1;
    end
  end

  axis_skid_buf #(.DATA_W(DATA_W), .USER_W(USER_W)) u_mmio_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_st  (mmio_in),
    .out_st (o_mmio_rx_st)
  );

  axis_skid_buf #(.DATA_W(DATA_W), .USER_W(USER_W)) u_afu_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_st  (afu_in),
    .out_st (o_afu_rx_st)
  );

endmodule

// File: tb/tb_pcie_rx_demux.sv
// Bench for pcie_rx_demux: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed checkpoints.
module tb_pcie_rx_demux;
  localparam int unsigned DW = 256;
  localparam int unsigned UW = 10;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  typedef struct {
    int          cyc;
    bit          last;
    bit          inpkt;
    logic [15:0] tag;
  } log_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] mmio_cnt;
  logic [CW-1:0] afu_cnt;
  logic          in_pkt;

  always #5 clk = ~clk;

  pcie_ss_axis_if #(.DATA_W(DW), .USER_W(UW)) rx_if ();
  pcie_ss_axis_if #(.DATA_W(DW), .USER_W(UW)) mmio_if ();
  pcie_ss_axis_if #(.DATA_W(DW), .USER_W(UW)) afu_if ();

  pcie_rx_demux #(
    .FIM_PF_NUM     (0),
    .FIM_BAR_NUM    (0),
    .FIM_ADDR_LIMIT (64'h0008_0000),
    .CNT_W          (CW),
    .DATA_W         (DW),
    .USER_W         (UW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_pcie_rx_st   (rx_if),
    .o_mmio_rx_st   (mmio_if),
    .o_afu_rx_st    (afu_if),
    .o_mmio_tlp_cnt (mmio_cnt),
    .o_afu_tlp_cnt  (afu_cnt),
    .o_in_pkt       (in_pkt)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [DW-1:0] mk_hdr(input logic [7:0] fmt, input logic [63:0] addr,
                                           input logic [2:0] pf, input logic vfa,
                                           input logic [3:0] bar, input logic [15:0] tag);
    logic [DW-1:0] h;
    h = '0;
    h[31:24] = fmt;
    if (fmt == 8'h20 || fmt == 8'h60) h[95:64] = addr[63:32];
    h[127:96]  = addr[31:0];
    h[162:160] = pf;
    h[174]     = vfa;
    h[181:178] = bar;
    h[255:240] = tag;
    return h;
  endfunction

  function automatic beat_t mk_beat(input logic [DW-1:0] d, input logic last);
    beat_t b;
    b.data = d;
    b.keep = last ? KW'(32'h0000_ffff) : '1;
    b.last = last;
    b.user = d[249:240];
    return b;
  endfunction

  // Payload beats deliberately look like MMIO write headers.
  function automatic logic [DW-1:0] mk_pay(input logic [15:0] tag);
    return mk_hdr(8'h60, 64'h10, 3'd0, 1'b0, 4'd0, tag);
  endfunction

  // ---------------- reference model ----------------
  function automatic bit exp_is_mmio(input logic [DW-1:0] h);
    logic [7:0]  f;
    logic [63:0] a;
    bit          mem;
    f   = h[31:24];
    mem = (f == 8'h00) || (f == 8'h20) || (f == 8'h40) || (f == 8'h60);
    a   = (f == 8'h20 || f == 8'h60) ? {h[95:64], h[127:96]} : {32'd0, h[127:96]};
    return mem && (h[162:160] == 3'd0) && !h[174] && (h[181:178] == 4'd0) &&
           (a < 64'h8_0000);
  endfunction

  beat_t         q_mmio[$];
  beat_t         q_afu[$];
  bit            m_in_pkt = 0;
  bit            m_route_mmio = 0;
  bit            m_rdy_en = 0;
  bit            model_valid = 0;
  logic [CW-1:0] m_cnt_mmio = '0;
  logic [CW-1:0] m_cnt_afu = '0;
  log_t          afu_log[$];
  log_t          mmio_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle: compare DUT against model, then advance model to the next edge.
  always @(negedge clk) begin
    bit    dest_mmio;
    int    occ;
    beat_t bi;
    if (model_valid) begin
      chk("mmio_tvalid", 512'(mmio_if.tvalid), 512'(q_mmio.size() != 0));
      if (mmio_if.tvalid && q_mmio.size() != 0)
        chk("mmio_beat", 512'({mmio_if.tdata, mmio_if.tkeep, mmio_if.tlast,
                               mmio_if.tuser_vendor}), 512'(q_mmio[0]));
      chk("afu_tvalid", 512'(afu_if.tvalid), 512'(q_afu.size() != 0));
      if (afu_if.tvalid && q_afu.size() != 0)
        chk("afu_beat", 512'({afu_if.tdata, afu_if.tkeep, afu_if.tlast,
                              afu_if.tuser_vendor}), 512'(q_afu[0]));
      dest_mmio = m_in_pkt ? m_route_mmio : exp_is_mmio(rx_if.tdata);
      occ = dest_mmio ? q_mmio.size() : q_afu.size();
      chk("in_tready", 512'(rx_if.tready), 512'(m_rdy_en && (occ < 2)));
      chk("mmio_cnt", 512'(mmio_cnt), 512'(m_cnt_mmio));
      chk("afu_cnt", 512'(afu_cnt), 512'(m_cnt_afu));
      chk("in_pkt", 512'(in_pkt), 512'(m_in_pkt));
    end
    if (!rst_n) begin
      q_mmio.delete();
      q_afu.delete();
      m_in_pkt    = 0;
      m_cnt_mmio  = '0;
      m_cnt_afu   = '0;
      m_rdy_en    = 0;
      model_valid = 1;
    end else if (model_valid) begin
      if (mmio_if.tvalid && mmio_if.tready) begin
        mmio_log.push_back('{cyc, mmio_if.tlast, in_pkt, mmio_if.tdata[255:240]});
        if (q_mmio.size() != 0) void'(q_mmio.pop_front());
      end
      if (afu_if.tvalid && afu_if.tready) begin
        afu_log.push_back('{cyc, afu_if.tlast, in_pkt, afu_if.tdata[255:240]});
        if (q_afu.size() != 0) void'(q_afu.pop_front());
      end
      if (rx_if.tvalid && rx_if.tready) begin
        bi = {rx_if.tdata, rx_if.tkeep, rx_if.tlast, rx_if.tuser_vendor};
        if (!m_in_pkt) begin
          m_route_mmio = exp_is_mmio(rx_if.tdata);
          if (m_route_mmio) m_cnt_mmio = m_cnt_mmio + 1'b1;
          else              m_cnt_afu  = m_cnt_afu + 1'b1;
          m_in_pkt = !rx_if.tlast;
        end else if (rx_if.tlast) begin
          m_in_pkt = 0;
        end
        if (m_route_mmio) q_mmio.push_back(bi);
        else              q_afu.push_back(bi);
      end
      m_rdy_en = 1;
    end
  end

  // Present one beat from #1 after a rising edge until it is accepted.
  task automatic send(input beat_t b);
    bit acc;
    int n;
    acc = 0;
    n   = 0;
    rx_if.tvalid       = 1'b1;
    rx_if.tdata        = b.data;
    rx_if.tkeep        = b.keep;
    rx_if.tlast        = b.last;
    rx_if.tuser_vendor = b.user;
    do begin
      @(negedge clk);
      acc = rx_if.tready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    chk("send_accept", 512'(acc), 512'(1));
    rx_if.tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int          t4_cyc;
    logic [3:0]  lp;
    logic [3:0]  ip;
    rx_if.tvalid       = 1'b0;
    rx_if.tdata        = '0;
    rx_if.tkeep        = '0;
    rx_if.tlast        = 1'b0;
    rx_if.tuser_vendor = '0;
    mmio_if.tready     = 1'b1;
    afu_if.tready      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state.
    @(negedge clk);
    chk("rst_in_tready", 512'(rx_if.tready), 512'(0));
    chk("rst_mmio_tvalid", 512'(mmio_if.tvalid), 512'(0));
    chk("rst_afu_tvalid", 512'(afu_if.tvalid), 512'(0));
    chk("rst_in_pkt", 512'(in_pkt), 512'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Single-beat MWr64 to FIM space: one cycle after acceptance, MMIO only.
    send(mk_beat(mk_hdr(8'h60, 64'h1000, 3'd0, 1'b0, 4'd0, 16'h0101), 1'b1));
    @(negedge clk);
    chk("t1_mmio_tvalid", 512'(mmio_if.tvalid), 512'(1));
    chk("t1_afu_tvalid", 512'(afu_if.tvalid), 512'(0));
    chk("t1_mmio_tag", 512'(mmio_if.tdata[255:240]), 512'(16'h0101));
    chk("t1_mmio_cnt", 512'(mmio_cnt), 512'(1));
    @(posedge clk);
    #1;

    // Boundary and miss cases.
    send(mk_beat(mk_hdr(8'h20, 64'h8_0000, 3'd0, 1'b0, 4'd0, 16'h0201), 1'b1));
    send(mk_beat(mk_hdr(8'h20, 64'h1000, 3'd0, 1'b0, 4'd2, 16'h0202), 1'b1));
    send(mk_beat(mk_hdr(8'h00, 64'h7_fffc, 3'd0, 1'b0, 4'd0, 16'h0203), 1'b1));
    send(mk_beat(mk_hdr(8'h40, 64'h100, 3'd0, 1'b1, 4'd0, 16'h0204), 1'b1));
    send(mk_beat(mk_hdr(8'h60, 64'h100, 3'd1, 1'b0, 4'd0, 16'h0205), 1'b1));
    send(mk_beat(mk_hdr(8'h20, 64'h1_0000_0000, 3'd0, 1'b0, 4'd0, 16'h0206), 1'b1));
    idle(3);
    @(negedge clk);
    chk("t2_afu_cnt", 512'(afu_cnt), 512'(5));
    chk("t2_mmio_cnt", 512'(mmio_cnt), 512'(2));
    @(posedge clk);
    #1;

    // 4-beat completion then 1-beat MMIO write, back-to-back.
    afu_log.delete();
    mmio_log.delete();
    send(mk_beat(mk_hdr(8'h4A, 64'h0, 3'd0, 1'b0, 4'd0, 16'h0301), 1'b0));
    send(mk_beat(mk_pay(16'h0302), 1'b0));
    send(mk_beat(mk_pay(16'h0303), 1'b0));
    send(mk_beat(mk_pay(16'h0304), 1'b1));
    send(mk_beat(mk_hdr(8'h40, 64'h20, 3'd0, 1'b0, 4'd0, 16'h0305), 1'b1));
    idle(4);
    chk("t3_afu_beats", 512'(afu_log.size()), 512'(4));
    chk("t3_mmio_beats", 512'(mmio_log.size()), 512'(1));
    lp = '0;
    ip = '0;
    for (int i = 0; i < afu_log.size() && i < 4; i++) begin
      lp[i] = afu_log[i].last;
      ip[i] = afu_log[i].inpkt;
    end
    chk("t3_tlast_pattern", 512'(lp), 512'(4'b1000));
    chk("t3_in_pkt_pattern", 512'(ip), 512'(4'b0111));
    if (afu_log.size() == 4 && mmio_log.size() == 1) begin
      chk("t3_afu_contig", 512'(afu_log[3].cyc - afu_log[0].cyc), 512'(3));
      chk("t3_mmio_after", 512'(mmio_log[0].cyc - afu_log[3].cyc), 512'(1));
    end

    // AFU stalled for 10 cycles mid 8-beat TLP; an MMIO TLP is queued behind it.
    afu_log.delete();
    mmio_log.delete();
    send(mk_beat(mk_hdr(8'h4A, 64'h0, 3'd0, 1'b0, 4'd0, 16'h0401), 1'b0));
    send(mk_beat(mk_pay(16'h0402), 1'b0));
    send(mk_beat(mk_pay(16'h0403), 1'b0));
    afu_if.tready = 1'b0;
    fork
      begin
        repeat (4) @(negedge clk);
        chk("t4_stall_in_tready", 512'(rx_if.tready), 512'(0));
        chk("t4_stall_afu_tvalid", 512'(afu_if.tvalid), 512'(1));
      end
      begin
        repeat (10) @(posedge clk);
        #1 afu_if.tready = 1'b1;
      end
    join_none
    for (int i = 4; i <= 8; i++) send(mk_beat(mk_pay(16'h0400 + 16'(i)), i == 8));
    send(mk_beat(mk_hdr(8'h60, 64'h40, 3'd0, 1'b0, 4'd0, 16'h0409), 1'b1));
    idle(6);
    chk("t4_afu_beats", 512'(afu_log.size()), 512'(8));
    for (int i = 0; i < afu_log.size() && i < 8; i++)
      chk("t4_order", 512'(afu_log[i].tag), 512'(16'h0401 + 16'(i)));
    chk("t4_mmio_beats", 512'(mmio_log.size()), 512'(1));
    if (afu_log.size() == 8 && mmio_log.size() == 1) begin
      t4_cyc = mmio_log[0].cyc - afu_log[7].cyc;
      chk("t4_mmio_behind", 512'(t4_cyc > 0), 512'(1));
    end

    // Reset during beat 3 of a 6-beat AFU TLP.
    afu_if.tready = 1'b0;
    send(mk_beat(mk_hdr(8'h4A, 64'h0, 3'd0, 1'b0, 4'd0, 16'h0501), 1'b0));
    send(mk_beat(mk_pay(16'h0502), 1'b0));
    rx_if.tvalid = 1'b1;
    rx_if.tdata  = mk_pay(16'h0503);
    rx_if.tlast  = 1'b0;
    rst_n        = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t5_mmio_tvalid", 512'(mmio_if.tvalid), 512'(0));
    chk("t5_afu_tvalid", 512'(afu_if.tvalid), 512'(0));
    chk("t5_mmio_cnt", 512'(mmio_cnt), 512'(0));
    chk("t5_afu_cnt", 512'(afu_cnt), 512'(0));
    chk("t5_in_pkt", 512'(in_pkt), 512'(0));
    rx_if.tvalid  = 1'b0;
    afu_if.tready = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Fresh MMIO write after reset, then counter wrap at 17 MMIO SOPs.
    afu_log.delete();
    mmio_log.delete();
    send(mk_beat(mk_hdr(8'h60, 64'h2000, 3'd0, 1'b0, 4'd0, 16'h0601), 1'b1));
    @(negedge clk);
    chk("t6_mmio_tvalid", 512'(mmio_if.tvalid), 512'(1));
    chk("t6_afu_tvalid", 512'(afu_if.tvalid), 512'(0));
    chk("t6_mmio_tag", 512'(mmio_if.tdata[255:240]), 512'(16'h0601));
    @(posedge clk);
    #1;
    for (int i = 2; i <= 17; i++)
      send(mk_beat(mk_hdr(8'h40, 64'h100, 3'd0, 1'b0, 4'd0, 16'h0600 + 16'(i)), 1'b1));
    idle(4);
    @(negedge clk);
    chk("t6_mmio_cnt_wrap", 512'(mmio_cnt), 512'(1));
    chk("t6_afu_cnt", 512'(afu_cnt), 512'(0));
    chk("t6_mmio_beats", 512'(mmio_log.size()), 512'(17));
    chk("t6_afu_beats", 512'(afu_log.size()), 512'(0));
    chk("drain_mmio", 512'(q_mmio.size()), 512'(0));
    chk("drain_afu", 512'(q_afu.size()), 512'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
